// File: rtl/dns_resp_sched.sv
// Sequencer for the DNS response header builder: issues a run of header requests over a
// req/ack handshake with a programmable inter-packet gap, incrementing the DNS ID per packet.
module dns_resp_sched #(
  parameter int unsigned GAP_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk156,
  input  logic             sys_rst,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [CNT_W-1:0] cfg_pkt_count,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [15:0]      cfg_id_base,
  input  logic             cfg_rd,
  input  logic [3:0]       cfg_rcode,
  output logic             gen_req,
  input  logic             gen_ack,
  output logic [15:0]      hdr_id,
  output logic [15:0]      hdr_flags,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StReq, StGap, StFin} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             rd_q, rd_d;
  logic [3:0]       rcode_q, rcode_d;
  logic [15:0]      hdr_id_q, hdr_id_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] sent_inc;

  assign sent_inc = (sent_q == '1) ? sent_q : sent_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    rd_d        = rd_q;
    rcode_d     = rcode_q;
    hdr_id_d    = hdr_id_q;
    sent_d      = sent_q;
    stop_pend_d = stop_pend_q;

    unique case (state_q)
      StIdle: begin
        // A simultaneous stop cancels the start.
        if (cfg_start && !cfg_stop) begin
          limit_d     = cfg_pkt_count;
          gap_d       = cfg_gap;
          rd_d        = cfg_rd;
          rcode_d     = cfg_rcode;
          hdr_id_d    = cfg_id_base;
          sent_d      = '0;
          stop_pend_d = 1'b0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (gen_ack) begin
          sent_d   = sent_inc;
          hdr_id_d = hdr_id_q + 16'd1;
          if (stop_pend_q || cfg_stop) begin
            state_d = StFin;
          end else if ((limit_q != '0) && (sent_inc == limit_q)) begin
            state_d = StFin;
          end else if (gap_q == '0) begin
            state_d = StReq;
          end else begin
            state_d   = StGap;
            gap_cnt_d = gap_q - GAP_W'(1);
          end
        end else if (cfg_stop) begin
          // Request cannot be withdrawn, so the stop waits for the ack.
          stop_pend_d = 1'b1;
        end
      end
      StGap: begin
        if (cfg_stop) begin
          state_d = StFin;
        end else if (gap_cnt_q == '0) begin
          state_d = StReq;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      StFin: begin
        stop_pend_d = 1'b0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      limit_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      rd_q        <= 1'b0;
      rcode_q     <= 4'd0;
      hdr_id_q    <= 16'd0;
      sent_q      <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      limit_q     <= limit_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      rd_q        <= rd_d;
      rcode_q     <= rcode_d;
      hdr_id_q    <= hdr_id_d;
      sent_q      <= sent_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign gen_req    = (state_q == StReq);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign hdr_id     = hdr_id_q;
  assign sent_count = sent_q;
  // {qr, opcode, aa, tc, rd, ra, z, rcode}
  assign hdr_flags  = {1'b1, 4'd0, 1'b0, 1'b0, rd_q, 1'b0, 3'd0, rcode_q};

endmodule

// File: doc/dns_resp_sched.md
Name: dns_resp_sched

Overview:
- Sequencing controller for the DNS response packet builder in the DDoS emulator.
- On a start command, it issues a programmed number of header requests to the builder over a req/ack handshake, with a programmable inter-packet gap.
- It presents the DNS header ID and flags word for each packet. The ID increments per packet.
- It reports progress, and a done pulse on completion or stop.

Parameters:
- GAP_W, 16, width of inter-packet gap counter (cycles)
- CNT_W, 32, width of packet count limit and sent counter

Ports:
- clk156  in  1  system clock, all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- cfg_start  in  1  start pulse; ignored while busy
- cfg_stop  in  1  stop request; level or pulse
- cfg_pkt_count  in  CNT_W  packets per run; 0 = unlimited
- cfg_gap  in  GAP_W  idle cycles between ack and next req
- cfg_id_base  in  16  first DNS ID of run
- cfg_rd  in  1  RD flag value
- cfg_rcode  in  4  RCODE value
- gen_req  out  1  header valid, request to builder
- gen_ack  in  1  builder accepted current header
- hdr_id  out  16  DNS ID for current request
- hdr_flags  out  16  {qr,opcode[3:0],aa,tc,rd,ra,z[2:0],rcode[3:0]}, bit15 = qr
- busy  out  1  run in progress
- sent_count  out  CNT_W  packets acknowledged this run; saturates at all-ones
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values:
  - State IDLE.
  - gen_req=0, busy=0, done=0.
  - hdr_id=0, hdr_flags=16'h8000, sent_count=0.
  - Stop-pending flag cleared.
- Flags field values:
  - qr=1, opcode=0, aa=0, tc=0, ra=0, z=0.
  - rd and rcode are latched from cfg at start and held for the whole run.
- State IDLE:
  - busy=0.
  - cfg_start=1 and cfg_stop=0:
    - latch cfg_pkt_count, cfg_gap, cfg_rd, cfg_rcode
    - hdr_id<=cfg_id_base, sent_count<=0
    - go REQ next cycle (gen_req high one cycle after the start pulse)
  - cfg_start together with cfg_stop: stop wins; stay IDLE, no done.
- State REQ:
  - gen_req=1, busy=1.
  - hdr_id and hdr_flags are stable until ack.
  - gen_req is never withdrawn before gen_ack.
  - On gen_ack:
    - sent_count+1 (saturating)
    - hdr_id+1, wrapping 16'hFFFF->16'h0000
    - then evaluate the next state in this priority order:
    - (a) stop pending, or cfg_stop this cycle -> FIN
    - (b) limit!=0 and new sent_count==limit -> FIN
    - (c) gap==0 -> stay REQ; gen_req remains 1, giving back-to-back packets at 1 per cycle
    - (d) else -> GAP with gap_cnt<=gap-1
  - cfg_stop without gen_ack sets stop-pending; the pending stop is honoured at the next ack.
- State GAP:
  - gen_req=0, busy=1.
  - gap_cnt decrements each cycle. At gap_cnt==0 -> REQ, so gen_req is low exactly cfg_gap cycles.
  - cfg_stop in GAP -> FIN next cycle.
- State FIN:
  - done=1 for one cycle, busy=1, gen_req=0; then IDLE.
  - sent_count and hdr_id hold their final values until the next start.
- Latched config is unaffected by cfg changes mid-run.
- sys_rst mid-run:
  - returns to IDLE with reset values next cycle
  - no done pulse; an in-flight req is dropped
- gen_ack while gen_req=0 is ignored.

Test Plan:
- Finite run with gap:
  - Stimulus: pkt_count=3, gap=2, id_base=16'h1234, rd=1, rcode=0; start; ack each req after 1 cycle.
  - Required: hdr_id 1234/1235/1236; hdr_flags=16'h8100; gen_req low exactly 2 cycles between packets; sent_count=3; single done pulse; busy drops the cycle after done.
- Back-to-back:
  - Stimulus: gap=0, pkt_count=4, gen_ack tied high.
  - Required: gen_req high 4 consecutive cycles; IDs base..base+3; done on the following cycle.
- ID wrap and flags:
  - Stimulus: id_base=16'hFFFE, pkt_count=3, rd=0, rcode=3.
  - Required: IDs FFFE, FFFF, 0000; hdr_flags=16'h8003.
- Stop handling:
  - Stimulus: pkt_count=0 (unlimited), gap=5; stop during GAP.
  - Required: FIN next cycle, done pulse.
  - Stimulus: stop in REQ with ack held off 3 cycles.
  - Required: gen_req stays high until ack, then FIN; sent_count increments once.
- Start corner cases:
  - Stimulus: start+stop in the same IDLE cycle.
  - Required: no activity.
  - Stimulus: start while busy.
  - Required: ignored; IDs and count unchanged.
- Reset mid-run:
  - Stimulus: assert sys_rst during REQ.
  - Required: next cycle gen_req=0, busy=0, hdr_id=0, sent_count=0, no done pulse.
